uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_sync2.sv | 32 +++
 rtl/uart_rx.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Purpose: shared types and constants for the UART receiver.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Optional feature macro: UART_RX_PARITY_EN adds the PARITY state to the enum.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 434;  // 50 MHz / 115200 baud
  localparam int DATA_BITS            = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_BREAK
  } state_e;

  // Returns 1 when data plus its parity bit carry an odd number of ones,
  // i.e. the even-parity check has failed.
  function automatic logic even_parity_bad(input logic [DATA_BITS-1:0] data,
                                           input logic par_bit);
    return ^{data, par_bit};
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Purpose: two-flop synchronizer for an asynchronous level, resets to 1 (UART idle).
// Latency: 2 clk cycles from d to q.
// Backpressure: none; free-running.
// Ports: clk, rst (sync, active-high), d (async in), q (synchronized out).
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Purpose: UART receiver, 8 data bits LSB first, optional even parity, 1 stop bit.
// Latency: byte presented on the cycle after the stop-bit mid-sample (+2 cycles input sync).
// Backpressure: none into the line; an unconsumed byte is overwritten and overrun pulses.
// Ports: clk, rst (sync, active-high), rxd (async serial, idle high),
//        rx_data/rx_valid/rx_ready (valid-ready byte output),
//        frame_err/overrun/parity_err (one-cycle status pulses).
// Optional feature macro: UART_RX_PARITY_EN (even parity bit between data and stop).
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 parity_err
);

  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
  // Start bit is checked at its middle; every later sample lands one full
  // bit period after the previous one, so they stay mid-bit too.
  localparam logic [15:0] HALF = 16'((CLKS_PER_BIT - 1) >> 1);

  logic rxd_s;

  uart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxd_s)
  );

  state_e               state_q,     state_d;
  logic [15:0]          cnt_q,       cnt_d;
  logic [2:0]           bit_cnt_q,   bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q,     shift_d;
  logic [DATA_BITS-1:0] rx_data_q,   rx_data_d;
  logic                 rx_valid_q,  rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q,   overrun_d;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err_q, parity_err_d;
  logic                 par_bad_q,    par_bad_d;   // current frame failed parity
`endif

  logic sample;
  logic deliver;
  logic handshake;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    frame_err_d = 1'b0;
    deliver     = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_err_d = 1'b0;
    par_bad_d    = par_bad_q;
`endif
    sample = (cnt_q == LAST);

    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = 1'b0;
`endif
        if (!rxd_s) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == HALF) state_d = rxd_s ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (sample) begin
          shift_d   = {rxd_s, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (sample) begin
          if (even_parity_bad(shift_q, rxd_s)) begin
            parity_err_d = 1'b1;
            par_bad_d    = 1'b1;
          end
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (sample) begin
          if (rxd_s) begin
            state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
            deliver = !par_bad_q;
`else
            deliver = 1'b1;
`endif
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        // Line held low: wait for it to return high before hunting for a start.
        if (rxd_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Counter restarts on any state change and only runs in timed states.
    if ((state_d != state_q) || (state_q == ST_IDLE) || (state_q == ST_BREAK) || sample) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Output register: a delivery always wins, so the newest byte is kept;
  // overrun flags only a byte that was dropped without being accepted.
  always_comb begin
    handshake  = rx_valid_q && rx_ready;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q && !handshake;
    overrun_d  = 1'b0;
    if (deliver) begin
      rx_data_d  = shift_q;
      rx_valid_d = 1'b1;
      overrun_d  = rx_valid_q && !handshake;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
      par_bad_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= parity_err_d;
      par_bad_q    <= par_bad_d;
`endif
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
